varredura_matriz: RTL and testbench
===================================

Name: varredura_matriz

Overview:
- Downstream scan driver for the 5-row x 7-column LED matrix.
- Accepts a full 35-bit frame from the row shift-register stage through a valid/ready handshake and double-buffers it.
- Time-multiplexes the active frame onto the matrix one column at a time, with a blanking gap between columns to suppress ghosting.
- Drives the physical pins `acender_coluna` and `linhas`.

Parameters:
- N_COLUNAS, 7, number of matrix columns scanned.
- N_LINHAS, 5, number of matrix rows.
- DIV_COLUNA, 1000, clk cycles per column slot; must be >= BLANK+2.
- BLANK, 16, clk cycles at the start of each slot with every output dark; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- quadro_in  input  35  frame data, column-major: bits [c*5 +: 5] are rows 4..0 of column c.
- quadro_valid  input  1  upstream offers quadro_in.
- quadro_ready  output  1  shadow buffer free; capture occurs on valid&&ready.
- linhas  output  5  row drive, active-high.
- acender_coluna  output  7  column select, active-low one-hot.
- fim_quadro  output  1  one-cycle pulse at the end of each full 7-column scan.

Behaviour:
- Reset values:
  - active and shadow buffers = 0.
  - pending = 0.
  - div_cnt = 0, col_idx = 0.
  - state = APAGADO.
  - acender_coluna = 7'b1111111, linhas = 0, fim_quadro = 0.
- quadro_ready = !pending (combinational); it is 1 during and after reset.
- Capture:
  - On a cycle with quadro_valid && quadro_ready, the shadow buffer takes quadro_in and pending is set on the next edge.
  - While pending = 1, the upstream holds its data.
- div_cnt counts 0..DIV_COLUNA-1 and wraps. col_idx advances on each wrap, 6 -> 0.
- State machine:
  - APAGADO: entered when div_cnt = 0. Moves to ACESO when div_cnt = BLANK-1.
  - ACESO: ends at div_cnt = DIV_COLUNA-1, returning to APAGADO.
- Outputs are registered and follow state with one cycle of latency.
  - In APAGADO: acender_coluna = all ones, linhas = 0.
  - In ACESO: acender_coluna[col_idx] = 0 (others 1), linhas = active[col_idx*5 +: 5].
- Frame boundary: the cycle where div_cnt = DIV_COLUNA-1 and col_idx = 6.
  - fim_quadro is asserted in the following cycle for exactly one cycle.
  - If pending = 1, the shadow is copied to active on that same edge and pending clears. quadro_ready therefore rises in the first cycle of the new frame.
  - If a capture and the boundary coincide (pending was 0), the captured data goes to shadow only and becomes active at the next boundary.
- The active buffer never changes mid-frame, so no tearing.
- A frame of all zeros produces dark rows while column select still scans.
- Reset asserted mid-scan immediately forces all outputs dark and drops any pending frame.

Optional Feature:
- Macro BRILHO_EN.
- With the macro defined:
  - Extra input port brilho [3:0].
  - A 4-bit free-running pwm_cnt (reset 0, +1 per clk).
  - In ACESO, outputs are lit only when pwm_cnt < brilho, or always when brilho = 15. Otherwise they are dark, identical to APAGADO.
  - brilho = 0 keeps the matrix fully dark.
  - brilho is sampled every cycle; no synchronisation is required.
- Without the macro: no brilho port, and ACESO is always lit.

Decomposition:
- Package matriz_pkg holds:
  - N_COLUNAS, N_LINHAS.
  - COLUNAS_OFF = 7'b1111111.
  - The state enum {APAGADO, ACESO}.
  - The frame width constant QUADRO_W = N_COLUNAS*N_LINHAS.
- Sub-module divisor_varredura owns div_cnt and col_idx and produces three strobes: inicio_slot, fim_blank and fim_quadro_int.
- The top level holds the buffers, handshake, FSM and output registers.

Test Plan (DIV_COLUNA = 8, BLANK = 2):
- Release reset with no valid -> quadro_ready = 1, acender_coluna = 7'b1111111, linhas = 0 throughout, fim_quadro pulses every 56 cycles.
- Load a frame with column 0 = 5'b10101, column 6 = 5'b11111, others 0.
  - Handshake completes in 1 cycle; ready stays low until the frame boundary.
  - In the next scan, slot 0 shows acender_coluna = 7'b1111110 with linhas = 10101 in cycles 3..8 of the slot (registered, one-cycle lag), dark in cycles 1..2.
  - Slot 6 shows 7'b0111111 with 11111.
- Present a second frame while pending -> ready = 0, data held. The displayed pattern is unchanged until fim_quadro, then switches on the very next slot 0.
- Capture in the same cycle as the frame boundary -> old frame is shown for one more full scan, new frame appears after the following fim_quadro.
- Assert rst_n = 0 during ACESO of column 3 -> outputs go 7'b1111111 / 0 asynchronously, pending clears, and the scan restarts at column 0 after release.
- BRILHO_EN with brilho = 4 -> during ACESO, lit in 4 of every 16 pwm_cnt values. brilho = 0 -> always dark. brilho = 15 -> identical to the non-PWM build.

Source files
------------

// File: rtl/matriz_pkg.sv
// Shared constants and types for the 5x7 LED-matrix scan driver.
// Optional PWM brightness is enabled by defining BRILHO_EN.
package matriz_pkg;
  localparam int N_COLUNAS = 7;
  localparam int N_LINHAS  = 5;
  localparam int QUADRO_W  = N_COLUNAS * N_LINHAS;
  localparam int COL_W     = $clog2(N_COLUNAS);

  localparam logic [N_COLUNAS-1:0] COLUNAS_OFF = '1;

  typedef enum logic {
    APAGADO = 1'b0,
    ACESO   = 1'b1
  } estado_t;

  function automatic logic [N_COLUNAS-1:0] sel_coluna(
    input logic [COL_W-1:0] c
  );
    logic [N_COLUNAS-1:0] um;
    um = {{(N_COLUNAS-1){1'b0}}, 1'b1};
    return COLUNAS_OFF ^ (um << c);
  endfunction
endpackage

// File: rtl/varredura_matriz_divisor.sv
// Slot timer: div_cnt and col_idx, plus strobes that fire in the
// cycle before the edge they name (slot start, blank end, frame end).
module divisor_varredura
  import matriz_pkg::*;
#(
  parameter int DIV_COLUNA = 1000,
  parameter int BLANK      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [COL_W-1:0] o_col_idx,
  output logic             o_inicio_slot,
  output logic             o_fim_blank,
  output logic             o_fim_quadro_int
);
  localparam int CW = $clog2(DIV_COLUNA);
  localparam logic [CW-1:0]    ULTIMO  = CW'(DIV_COLUNA - 1);
  localparam logic [CW-1:0]    FIM_BL  = CW'(BLANK - 1);
  localparam logic [COL_W-1:0] COL_ULT = COL_W'(N_COLUNAS - 1);

  logic [CW-1:0]    r_div_cnt;
  logic [COL_W-1:0] r_col_idx;
  logic             w_wrap;

  assign w_wrap = r_div_cnt == ULTIMO;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_col_idx <= '0;
    end else if (w_wrap) begin
      r_div_cnt <= '0;
      r_col_idx <= (r_col_idx == COL_ULT) ? '0
                 : r_col_idx + COL_W'(1);
    end else begin
      r_div_cnt <= r_div_cnt + CW'(1);
    end
  end

  assign o_col_idx        = r_col_idx;
  assign o_inicio_slot    = w_wrap;
  assign o_fim_blank      = r_div_cnt == FIM_BL;
  assign o_fim_quadro_int = w_wrap && (r_col_idx == COL_ULT);
endmodule

// File: rtl/varredura_matriz.sv
// Double-buffered column scan driver for the 5x7 LED matrix.
// Define BRILHO_EN to add the 4-bit PWM brightness input brilho.
module varredura_matriz
  import matriz_pkg::*;
#(
  parameter int DIV_COLUNA = 1000,
  parameter int BLANK      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [QUADRO_W-1:0]  quadro_in,
  input  logic                 quadro_valid,
`ifdef BRILHO_EN
  input  logic [3:0]           brilho,
`endif
  output logic                 quadro_ready,
  output logic [N_LINHAS-1:0]  linhas,
  output logic [N_COLUNAS-1:0] acender_coluna,
  output logic                 fim_quadro
);
  logic [QUADRO_W-1:0]  r_ativo;
  logic [QUADRO_W-1:0]  r_sombra;
  logic                 r_pendente;
  estado_t              r_estado;
  estado_t              w_prox;
  logic [COL_W-1:0]     w_col_idx;
  logic                 w_inicio_slot;
  logic                 w_fim_blank;
  logic                 w_fim_quadro_int;
  logic                 w_captura;
  logic                 w_aceso;
  logic [N_LINHAS-1:0]  r_linhas;
  logic [N_COLUNAS-1:0] r_colunas;
  logic                 r_fim;

  divisor_varredura #(
    .DIV_COLUNA (DIV_COLUNA),
    .BLANK      (BLANK)
  ) u_div (
    .clk              (clk),
    .rst_n            (rst_n),
    .o_col_idx        (w_col_idx),
    .o_inicio_slot    (w_inicio_slot),
    .o_fim_blank      (w_fim_blank),
    .o_fim_quadro_int (w_fim_quadro_int)
  );

  assign quadro_ready = !r_pendente;
  assign w_captura    = quadro_valid && !r_pendente;

  // Capture and swap are exclusive: capture needs pending low,
  // swap needs it high, so a boundary capture waits a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ativo    <= '0;
      r_sombra   <= '0;
      r_pendente <= 1'b0;
    end else if (w_captura) begin
      r_sombra   <= quadro_in;
      r_pendente <= 1'b1;
    end else if (w_fim_quadro_int && r_pendente) begin
      r_ativo    <= r_sombra;
      r_pendente <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= APAGADO;
    end else begin
      r_estado <= w_prox;
    end
  end

  always_comb begin
    w_prox = r_estado;
    unique case (1'b1)
      w_inicio_slot: w_prox = APAGADO;
      w_fim_blank:   w_prox = ACESO;
      default:       ;
    endcase
  end

`ifdef BRILHO_EN
  logic [3:0] r_pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 4'd1;
    end
  end

  assign w_aceso = (w_prox == ACESO)
                && ((brilho == 4'hF) || (r_pwm_cnt < brilho));
`else
  assign w_aceso = w_prox == ACESO;
`endif

  // Output regs load from the next state, so the lit window is
  // exactly div_cnt = BLANK .. DIV_COLUNA-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_colunas <= COLUNAS_OFF;
      r_linhas  <= '0;
      r_fim     <= 1'b0;
    end else begin
      r_fim <= w_fim_quadro_int;
      if (w_aceso) begin
        r_colunas <= sel_coluna(w_col_idx);
        r_linhas  <= r_ativo[int'(w_col_idx)*N_LINHAS +: N_LINHAS];
      end else begin
        r_colunas <= COLUNAS_OFF;
        r_linhas  <= '0;
      end
    end
  end

  assign acender_coluna = r_colunas;
  assign linhas         = r_linhas;
  assign fim_quadro     = r_fim;
endmodule

// File: tb/tb_varredura_matriz.sv
// Scoreboard bench for varredura_matriz with DIV_COLUNA=8, BLANK=2.
`timescale 1ns/1ps
module tb_varredura_matriz;
  localparam int DIV = 8;
  localparam int BL  = 2;
  localparam int NC  = 7;
  localparam int NL  = 5;
  localparam int FW  = NC * NL;
  localparam int LIT = DIV - BL;
  localparam int PER = DIV * NC;

  localparam logic [FW-1:0] F1 =
    {5'b11111, 25'd0, 5'b10101};
  localparam logic [FW-1:0] F2 =
    {5'd0, 5'b01110, 5'd0, 5'b11000, 5'd0, 5'b00011, 5'd0};
  localparam logic [FW-1:0] F3 =
    {5'd0, 5'd0, 5'b00100, 5'b01010, 5'b10001, 5'd0, 5'd0};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] quadro_in = '0;
  logic          quadro_valid = 1'b0;
  logic          quadro_ready;
  logic [NL-1:0] linhas;
  logic [NC-1:0] acender_coluna;
  logic          fim_quadro;
`ifdef BRILHO_EN
  logic [3:0]    brilho = 4'hF;
`endif

  varredura_matriz #(
    .DIV_COLUNA (DIV),
    .BLANK      (BL)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .quadro_in      (quadro_in),
    .quadro_valid   (quadro_valid),
`ifdef BRILHO_EN
    .brilho         (brilho),
`endif
    .quadro_ready   (quadro_ready),
    .linhas         (linhas),
    .acender_coluna (acender_coluna),
    .fim_quadro     (fim_quadro)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NC-1:0] col;
    logic [NL-1:0] lin;
  } slot_t;

  slot_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nome,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nome, act, exp);
    end
  endtask

  task automatic expect_scan(input logic [FW-1:0] q);
    slot_t s;
    for (int c = 0; c < NC; c++) begin
      s.col = 7'h7F ^ (7'b1 << c);
      s.lin = q[c*NL +: NL];
      sb.push_back(s);
    end
  endtask

  // Monitor: one scoreboard entry per lit column slot
  int    cyc = 0;
  int    last_fim = -1;
  int    run = 0;
  int    gap = 0;
  bit    in_run = 0;
  bit    had_run = 0;
  bit    instavel = 0;
  slot_t cur;
  slot_t esp;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_run = 0;
      had_run = 0;
      run = 0;
      gap = 0;
      last_fim = -1;
    end else begin
      cyc++;
      if (fim_quadro) begin
        if (last_fim >= 0) chk("fim_period", cyc - last_fim, PER);
        last_fim = cyc;
      end
      if (acender_coluna != 7'h7F) begin
        if (!in_run) begin
          if (had_run) chk("blank_gap", gap, BL);
          in_run = 1;
          run = 1;
          cur = {acender_coluna, linhas};
          instavel = 0;
        end else begin
          run++;
          if ({acender_coluna, linhas} != cur) instavel = 1;
        end
      end else begin
        chk("dark_rows", linhas, 0);
        if (in_run) begin
          in_run = 0;
          had_run = 1;
          gap = 1;
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty: slot col=%b rows=%b unexpected",
                     cur.col, cur.lin);
          end else begin
            esp = sb.pop_front();
            chk("slot_col", cur.col, esp.col);
            chk("slot_rows", cur.lin, esp.lin);
            chk("slot_len", run, LIT);
            chk("slot_stable", instavel, 0);
          end
        end else begin
          gap++;
        end
      end
    end
  end

  task automatic wait_fim(input bit ready_low);
    int n;
    int bad;
    n = 0;
    bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (!fim_quadro && ready_low && quadro_ready) bad++;
    end while (!fim_quadro && n < 3*PER);
    if (!fim_quadro) begin
      checks++;
      failures++;
      $display("FAIL fim_timeout: none in %0d cycles, need 1", n);
    end
    if (ready_low) chk("ready_held_low", bad, 0);
  endtask

  initial begin
    expect_scan('0);
    repeat (3) @(negedge clk);
    chk("rst_ready", quadro_ready, 1);
    chk("rst_col", acender_coluna, 7'h7F);
    chk("rst_rows", linhas, 0);
    chk("rst_fim", fim_quadro, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    @(negedge clk);
    chk("ready_idle", quadro_ready, 1);
    quadro_in = F1;
    quadro_valid = 1'b1;
    @(negedge clk);
    quadro_valid = 1'b0;
    chk("hs_1cycle", quadro_ready, 0);
    wait_fim(1);
    chk("ready_at_fim", quadro_ready, 1);
    expect_scan(F1);

    quadro_in = F2;
    quadro_valid = 1'b1;
    @(negedge clk);
    chk("hs2", quadro_ready, 0);
    quadro_in = F3;
    repeat (20) @(negedge clk);
    chk("held_not_ready", quadro_ready, 0);
    quadro_valid = 1'b0;
    wait_fim(1);
    chk("swap2_ready", quadro_ready, 1);
    expect_scan(F2);

    repeat (PER-1) @(negedge clk);
    chk("pre_boundary_fim", fim_quadro, 0);
    quadro_in = F3;
    quadro_valid = 1'b1;
    @(negedge clk);
    quadro_valid = 1'b0;
    chk("coinc_fim", fim_quadro, 1);
    chk("coinc_pending", quadro_ready, 0);
    expect_scan(F2);
    wait_fim(1);
    chk("coinc_ready", quadro_ready, 1);
    expect_scan(F3);

    quadro_in = F1;
    quadro_valid = 1'b1;
    @(negedge clk);
    quadro_valid = 1'b0;
    chk("hs3", quadro_ready, 0);
    repeat (3*DIV + BL + 1) @(negedge clk);
    chk("mid_col3", acender_coluna, 7'b1110111);
    chk("mid_rows3", linhas, 5'b01010);
    #1 rst_n = 1'b0;
    #1;
    chk("async_col", acender_coluna, 7'h7F);
    chk("async_rows", linhas, 0);
    chk("async_ready", quadro_ready, 1);
    chk("async_fim", fim_quadro, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    expect_scan('0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    wait_fim(0);
    chk("post_rst_ready", quadro_ready, 1);
    expect_scan('0);
    wait_fim(0);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
